// File: rtl/sysbus_pkg.sv
// Shared system-bus definitions for the memory bus arbiter slice.
//   arb_state_t    : arbiter FSM states (IDLE, REQ, RDRESP, WRDATA)
//   owner_t        : which cache currently owns the DRAM-side bus
//   BEATS_PER_LINE : data beats per 512-bit cache line on a 64-bit bus
//   TAG_WR_BIT     : value of the tag MSB that marks a write transaction
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b1
`endif

package sysbus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RDRESP = 2'd2,
        WRDATA = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int   BEATS_PER_LINE = 8;
    localparam logic TAG_WR_BIT     = `SYSBUS_WRITE;

endpackage

// File: rtl/arb_rr2_pick.sv
// Two-way grant picker for the memory bus arbiter.
//   i_req[0]     : I-cache requesting
//   i_req[1]     : D-cache requesting
//   i_last_grant : owner of the most recently completed transaction
//   o_grant      : selected owner (only meaningful when i_req != 0)
// MEM_ARB_DCACHE_PRIO_EN defined   : D-cache wins every tie, i_last_grant ignored.
// MEM_ARB_DCACHE_PRIO_EN undefined : a tie goes to the cache that was not served last.
module arb_rr2_pick
    import sysbus_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_grant,
    output owner_t     o_grant
);

`ifdef MEM_ARB_DCACHE_PRIO_EN
    always_comb begin
        o_grant = i_req[1] ? OWN_D : OWN_I;
    end
`else
    always_comb begin
        if (i_req == 2'b11) begin
            o_grant = (i_last_grant == OWN_D) ? OWN_I : OWN_D;
        end else if (i_req[0]) begin
            o_grant = OWN_I;
        end else begin
            o_grant = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single DRAM-side system bus between the I-cache (i_*) and the
// D-cache (d_*). One whole transaction is granted at a time:
//   read  = 1 request beat + BEATS response beats
//   write = 1 request beat + BEATS write-data beats
// The grant stays locked until the last beat; IDLE is visited between
// transactions, giving one cycle of arbitration latency.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   {i,d}_reqcyc/req/tag  : cache request or write-data beat in
//   {i,d}_reqack          : ack of request/data beat to that cache
//   {i,d}_respcyc/resp/tag: response beat out to that cache
//   {i,d}_respack         : cache accepts response beat
//   m_reqcyc/req/reqtag   : request/data beat to memory, m_reqack back
//   m_respcyc/resp/resptag: response beat from memory, m_respack back
// Build option: MEM_ARB_DCACHE_PRIO_EN selects fixed D-cache priority
// instead of round-robin (see arb_rr2_pick).
module mem_bus_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = BEATS_PER_LINE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_reqcyc,
    output logic                      i_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    output logic                      i_respcyc,
    input  logic                      i_respack,
    output logic [BUS_DATA_WIDTH-1:0] i_resp,
    output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
    input  logic                      d_reqcyc,
    output logic                      d_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    output logic                      d_respcyc,
    input  logic                      d_respack,
    output logic [BUS_DATA_WIDTH-1:0] d_resp,
    output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
    output logic                      m_reqcyc,
    input  logic                      m_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_reqtag,
    input  logic                      m_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_resptag,
    output logic                      m_respack
);

    localparam int                CNT_W     = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t                r_state;
    owner_t                    r_owner;
    owner_t                    r_last_grant;
    logic                      r_is_wr;
    logic [CNT_W-1:0]          r_beat_cnt;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;

    owner_t                    w_grant;
    logic [1:0]                w_req_vec;
    logic                      w_own_reqcyc;
    logic                      w_own_respack;
    logic [BUS_DATA_WIDTH-1:0] w_own_req;
    logic [BUS_TAG_WIDTH-1:0]  w_own_reqtag;
    logic [BUS_TAG_WIDTH-1:0]  w_pick_tag;
    logic                      w_wr_beat;
    logic                      w_rd_beat;
    logic                      w_last_beat;

    assign w_req_vec     = {d_reqcyc, i_reqcyc};
    assign w_own_reqcyc  = (r_owner == OWN_D) ? d_reqcyc  : i_reqcyc;
    assign w_own_respack = (r_owner == OWN_D) ? d_respack : i_respack;
    assign w_own_req     = (r_owner == OWN_D) ? d_req     : i_req;
    assign w_own_reqtag  = (r_owner == OWN_D) ? d_reqtag  : i_reqtag;
    assign w_pick_tag    = (w_grant == OWN_D) ? d_reqtag  : i_reqtag;

    // A beat only counts on a real handshake; memory stalls simply hold the count.
    assign w_wr_beat   = (r_state == WRDATA) && w_own_reqcyc && m_reqack;
    assign w_rd_beat   = (r_state == RDRESP) && m_respcyc && w_own_respack;
    assign w_last_beat = (w_wr_beat || w_rd_beat) && (r_beat_cnt == LAST_BEAT);

    arb_rr2_pick u_pick (
        .i_req        (w_req_vec),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= OWN_I;
            r_last_grant <= OWN_D;
            r_is_wr      <= 1'b0;
            r_beat_cnt   <= '0;
            r_tag        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req_vec) begin
                        r_owner <= w_grant;
                        r_tag   <= w_pick_tag;
                        r_is_wr <= (w_pick_tag[BUS_TAG_WIDTH-1] == TAG_WR_BIT);
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    // Owner withdrawing before the ack abandons the transaction
                    // without counting as a service, so last_grant is untouched.
                    if (!w_own_reqcyc) begin
                        r_state <= IDLE;
                    end else if (m_reqack) begin
                        r_state    <= r_is_wr ? WRDATA : RDRESP;
                        r_beat_cnt <= '0;
                    end
                end
                RDRESP, WRDATA: begin
                    if (w_last_beat) begin
                        r_state      <= IDLE;
                        r_last_grant <= r_owner;
                    end else if (w_wr_beat || w_rd_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        i_reqack  = 1'b0;
        i_respcyc = 1'b0;
        i_resp    = '0;
        i_resptag = '0;
        d_reqack  = 1'b0;
        d_respcyc = 1'b0;
        d_resp    = '0;
        d_resptag = '0;
        m_reqcyc  = 1'b0;
        m_req     = '0;
        m_reqtag  = '0;
        m_respack = 1'b0;
        case (r_state)
            REQ, WRDATA: begin
                m_reqcyc = w_own_reqcyc;
                m_req    = w_own_req;
                // Data beats carry the tag captured at arbitration time.
                m_reqtag = (r_state == REQ) ? w_own_reqtag : r_tag;
                if (r_owner == OWN_D) begin
                    d_reqack = m_reqack;
                end else begin
                    i_reqack = m_reqack;
                end
            end
            RDRESP: begin
                m_respack = w_own_respack;
                if (r_owner == OWN_D) begin
                    d_respcyc = m_respcyc;
                    d_resp    = m_resp;
                    d_resptag = m_resptag;
                end else begin
                    i_respcyc = m_respcyc;
                    i_resp    = m_resp;
                    i_resptag = m_resptag;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int NB    = 8;
    localparam int LIMIT = 200;
`ifdef MEM_ARB_DCACHE_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam logic [TW-1:0] TAG_I  = 13'h0005;
    localparam logic [TW-1:0] TAG_D  = 13'h0006;
    localparam logic [TW-1:0] TAG_WR = 13'h1007;
    localparam logic [DW-1:0] WD     = 64'hD0D0_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    c_reqcyc;
    logic [1:0]    c_respack;
    logic [DW-1:0] c_req    [2];
    logic [TW-1:0] c_reqtag [2];

    logic          i_reqack, i_respcyc, d_reqack, d_respcyc;
    logic [DW-1:0] i_resp, d_resp, m_req, m_resp;
    logic [TW-1:0] i_resptag, d_resptag, m_reqtag, m_resptag;
    logic          m_reqcyc, m_reqack, m_respcyc, m_respack;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .i_reqcyc(c_reqcyc[0]), .i_reqack(i_reqack), .i_req(c_req[0]), .i_reqtag(c_reqtag[0]),
        .i_respcyc(i_respcyc), .i_respack(c_respack[0]), .i_resp(i_resp), .i_resptag(i_resptag),
        .d_reqcyc(c_reqcyc[1]), .d_reqack(d_reqack), .d_req(c_req[1]), .d_reqtag(c_reqtag[1]),
        .d_respcyc(d_respcyc), .d_respack(c_respack[1]), .d_resp(d_resp), .d_resptag(d_resptag),
        .m_reqcyc(m_reqcyc), .m_reqack(m_reqack), .m_req(m_req), .m_reqtag(m_reqtag),
        .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag), .m_respack(m_respack)
    );

    logic [236:0] all_out;
    assign all_out = {i_reqack, i_respcyc, i_resp, i_resptag,
                      d_reqack, d_respcyc, d_resp, d_resptag,
                      m_reqcyc, m_req, m_reqtag, m_respack};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_of(input int s);
        return (s != 0) ? d_reqack : i_reqack;
    endfunction

    function automatic logic resp_of(input int s);
        return (s != 0) ? d_respcyc : i_respcyc;
    endfunction

    // ---------------- observation counters ----------------
    int            i_beats = 0, d_beats = 0, d_resp_seen = 0, m_hs = 0, i_ack_bad = 0;
    logic [DW-1:0] mreq_q [$];

    // ---------------- transaction-level reference model ----------------
    // own_m: -1 = bus free, 0 = I, 1 = D. hdr_m: header not yet accepted.
    int            own_m = -1;
    int            last_m = 1;
    int            left_m = 0;
    bit            hdr_m = 1'b0;
    bit            wr_m = 1'b0;
    logic [TW-1:0] tag_m = '0;

    logic          e_ack [2];
    logic          e_rcyc [2];
    logic [DW-1:0] e_resp [2];
    logic [TW-1:0] e_rtag [2];
    logic          e_mcyc, e_mrack;
    logic [DW-1:0] e_mreq;
    logic [TW-1:0] e_mtag;

    initial begin
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                e_ack[s] = 1'b0; e_rcyc[s] = 1'b0; e_resp[s] = '0; e_rtag[s] = '0;
            end
            e_mcyc = 1'b0; e_mreq = '0; e_mtag = '0; e_mrack = 1'b0;
            if (own_m >= 0) begin
                if (hdr_m || wr_m) begin
                    e_mcyc       = c_reqcyc[own_m];
                    e_mreq       = c_req[own_m];
                    e_mtag       = hdr_m ? c_reqtag[own_m] : tag_m;
                    e_ack[own_m] = m_reqack;
                end else begin
                    e_rcyc[own_m] = m_respcyc;
                    e_resp[own_m] = m_resp;
                    e_rtag[own_m] = m_resptag;
                    e_mrack       = c_respack[own_m];
                end
            end
            chk("cycle_outputs", all_out,
                {e_ack[0], e_rcyc[0], e_resp[0], e_rtag[0],
                 e_ack[1], e_rcyc[1], e_resp[1], e_rtag[1],
                 e_mcyc, e_mreq, e_mtag, e_mrack});

            if (i_respcyc && c_respack[0]) i_beats++;
            if (d_respcyc && c_respack[1]) d_beats++;
            if (d_respcyc) d_resp_seen++;
            if (m_respcyc && m_respack) m_hs++;
            if (m_reqcyc && m_reqack) mreq_q.push_back(m_req);
            if (own_m == 1 && i_reqack) i_ack_bad++;

            if (reset) begin
                own_m = -1; last_m = 1;
            end else if (own_m < 0) begin
                if (c_reqcyc != 2'b00) begin
                    if (c_reqcyc == 2'b11) own_m = PRIO ? 1 : 1 - last_m;
                    else                   own_m = c_reqcyc[1] ? 1 : 0;
                    tag_m = c_reqtag[own_m];
                    wr_m  = tag_m[TW-1];
                    hdr_m = 1'b1;
                end
            end else if (hdr_m) begin
                if (!c_reqcyc[own_m]) own_m = -1;
                else if (m_reqack) begin hdr_m = 1'b0; left_m = NB; end
            end else begin
                if (wr_m ? (c_reqcyc[own_m] && m_reqack) : (m_respcyc && c_respack[own_m]))
                    left_m--;
                if (left_m == 0) begin last_m = own_m; own_m = -1; end
            end
        end
    end

    // ---------------- memory responder ----------------
    int stall_at = -1;
    int stall_len = 0;

    initial begin
        logic [DW-1:0] base;
        logic [TW-1:0] rtag;
        int            k, st;
        bit            rst;
        m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
        forever begin
            @(negedge clk);
            if (!reset && m_reqcyc && m_reqack && !m_reqtag[TW-1]) begin
                base = m_req; rtag = m_reqtag; k = 0; st = 0; rst = 1'b0;
                tick();
                while (k < NB) begin
                    if (k == stall_at && st < stall_len) begin
                        m_respcyc = 1'b0; st++;
                    end else begin
                        m_respcyc = 1'b1;
                        m_resp    = 64'hA5A5_0000_0000_0000 + base + DW'(k);
                        m_resptag = rtag;
                    end
                    @(negedge clk);
                    if (reset) rst = 1'b1;
                    else if (m_respcyc && m_respack) k++;
                    tick();
                    if (rst) break;
                end
                // One stray beat while the arbiter is back in IDLE; it must be dropped.
                if (!rst) begin
                    m_respcyc = 1'b1; m_resp = '1; m_resptag = '1;
                    tick();
                end
                m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
            end
        end
    end

    // ---------------- cache agent ----------------
    task automatic cache_txn(input int s, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                             input int drop_after);
        int n, k, beats;
        bit rst;
        c_req[s] = addr; c_reqtag[s] = tag; c_reqcyc[s] = 1'b1;
        if (drop_after > 0) begin
            repeat (drop_after) tick();
            c_reqcyc[s] = 1'b0;
            $display("txn side=%0d addr=%h dropped before ack", s, addr);
            return;
        end
        rst = 1'b0;
        for (n = 0; n < LIMIT; n++) begin
            @(negedge clk);
            if (reset) begin rst = 1'b1; break; end
            if (ack_of(s)) break;
        end
        if (!rst) chk("hdr_wait", n < LIMIT, 1);
        tick();
        beats = 0;
        if (rst) begin
            c_reqcyc[s] = 1'b0;
        end else if (tag[TW-1]) begin
            for (k = 0; k < NB; k++) begin
                c_req[s] = WD + DW'(k);
                for (n = 0; n < LIMIT; n++) begin
                    @(negedge clk);
                    if (reset) begin rst = 1'b1; break; end
                    if (ack_of(s)) break;
                end
                if (!rst) chk("wr_beat_wait", n < LIMIT, 1);
                tick();
                if (rst) break;
                beats++;
            end
            c_reqcyc[s] = 1'b0;
        end else begin
            c_reqcyc[s] = 1'b0;
            c_respack[s] = 1'b1;
            for (n = 0; n < LIMIT && beats < NB; n++) begin
                @(negedge clk);
                if (reset) begin rst = 1'b1; break; end
                if (resp_of(s)) beats++;
            end
            if (!rst) chk("rd_beat_wait", n < LIMIT, 1);
            tick();
            c_respack[s] = 1'b0;
        end
        $display("txn side=%0d addr=%h %s beats=%0d%s", s, addr, tag[TW-1] ? "write" : "read",
                 beats, rst ? " (reset)" : "");
    endtask

    // ---------------- directed scenarios ----------------
    int ib0, db0, hs0;

    initial begin
        c_reqcyc = '0; c_respack = '0;
        for (int s = 0; s < 2; s++) begin c_req[s] = '0; c_reqtag[s] = '0; end
        m_reqack = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", all_out, 0);
        tick();

        // Tie straight after reset.
        mreq_q.delete();
        fork
            cache_txn(0, 64'h1000, TAG_I, 0);
            cache_txn(1, 64'h3000, TAG_D, 0);
        join
        repeat (2) tick();
        chk("tie1_count", mreq_q.size(), 2);
        chk("tie1_first", mreq_q[0], PRIO ? 64'h3000 : 64'h1000);
        chk("tie1_second", mreq_q[1], PRIO ? 64'h1000 : 64'h3000);

        // Second tie: round-robin hands it back to I.
        mreq_q.delete();
        fork
            cache_txn(0, 64'h1040, TAG_I, 0);
            cache_txn(1, 64'h3040, TAG_D, 0);
        join
        repeat (2) tick();
        chk("tie2_first", mreq_q[0], PRIO ? 64'h3040 : 64'h1040);
        chk("tie2_second", mreq_q[1], PRIO ? 64'h1040 : 64'h3040);

        // I read alone with a 5-cycle memory stall after beat 3.
        mreq_q.delete();
        ib0 = i_beats; hs0 = m_hs; db0 = d_resp_seen;
        stall_at = 3; stall_len = 5;
        cache_txn(0, 64'h1000, TAG_I, 0);
        repeat (2) tick();
        stall_at = -1; stall_len = 0;
        chk("stall_i_beats", i_beats - ib0, 8);
        chk("stall_mem_acks", m_hs - hs0, 8);
        chk("stall_d_quiet", d_resp_seen - db0, 0);
        chk("stall_hdr", mreq_q[0], 64'h1000);
        chk("stall_count", mreq_q.size(), 1);

        // D write contends with an I read.
        mreq_q.delete();
        i_ack_bad = 0;
        fork
            cache_txn(1, 64'h2040, TAG_WR, 0);
            cache_txn(0, 64'h1080, TAG_I, 0);
        join
        repeat (2) tick();
        chk("wr_count", mreq_q.size(), 10);
        chk("wr_hdr", mreq_q[0], 64'h2040);
        for (int k = 0; k < NB; k++) chk($sformatf("wr_data%0d", k), mreq_q[k+1], WD + DW'(k));
        chk("wr_then_i", mreq_q[9], 64'h1080);
        chk("wr_i_ack_quiet", i_ack_bad, 0);

        // D wins the tie, then withdraws before the memory acks; I follows.
        mreq_q.delete();
        db0 = d_beats;
        m_reqack = 1'b0;
        fork
            cache_txn(1, 64'h3080, TAG_D, 3);
            cache_txn(0, 64'h1100, TAG_I, 0);
            begin repeat (5) tick(); m_reqack = 1'b1; end
        join
        repeat (2) tick();
        chk("abort_count", mreq_q.size(), 1);
        chk("abort_next_i", mreq_q[0], 64'h1100);
        chk("abort_d_beats", d_beats - db0, 0);

        // last_grant still I after the abort, so D takes this tie.
        mreq_q.delete();
        fork
            cache_txn(0, 64'h11C0, TAG_I, 0);
            cache_txn(1, 64'h30C0, TAG_D, 0);
        join
        repeat (2) tick();
        chk("post_abort_first", mreq_q[0], 64'h30C0);
        chk("post_abort_second", mreq_q[1], 64'h11C0);

        // Reset in the middle of a read.
        ib0 = i_beats;
        fork
            cache_txn(0, 64'h1000, TAG_I, 0);
            begin
                int n;
                for (n = 0; n < LIMIT; n++) begin
                    @(negedge clk); #1;
                    if (i_beats - ib0 >= 4) break;
                end
                chk("reset_wait_beat4", n < LIMIT, 1);
                tick();
                reset = 1'b1;
                tick();
                reset = 1'b0;
                @(negedge clk);
                chk("midreset_outputs", all_out, 0);
            end
        join
        repeat (2) tick();
        mreq_q.delete();
        ib0 = i_beats;
        cache_txn(0, 64'h1200, TAG_I, 0);
        repeat (2) tick();
        chk("after_reset_beats", i_beats - ib0, 8);
        chk("after_reset_hdr", mreq_q[0], 64'h1200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
